dc_miss_ctrl: RTL and testbench

DC_MISS_CTRL -- requirements
Module: dc_miss_ctrl

---
 rtl/dc_miss_ctrl.sv | 139 +++++++++++++
 tb/tb_dc_miss_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_miss_ctrl.sv
// Data-cache miss controller: optional victim write-back, line read, fill.
// Define DCACHE_WRITEBACK_EN to enable write-back of dirty victims.
module dc_miss_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         kill_i,
  input  logic         c_miss_i,
  input  logic [19:0]  c_addr_i,
  input  logic [1:0]   c_lru_way_i,
  input  logic         victim_dirty_i,
  input  logic [15:0]  victim_line_addr_i,
  input  logic [127:0] victim_data_i,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [19:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [127:0] mem_rdata_i,
  output logic         fill_en_o,
  output logic [1:0]   fill_way_o,
  output logic [19:0]  fill_addr_o,
  output logic [127:0] fill_data_o,
  output logic         stall_core_o,
  output logic [31:0]  miss_count_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
`ifdef DCACHE_WRITEBACK_EN
    WB_REQ   = 3'd1,
`endif
    FILL_REQ = 3'd2,
    FILL     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [15:0]  line_q;
  logic [1:0]   way_q;
  logic [127:0] rdata_q;
  logic [31:0]  miss_cnt_q;
  logic         accept;

`ifdef DCACHE_WRITEBACK_EN
  logic [15:0]  vline_q;
  logic [127:0] vdata_q;
  logic         unused;
  assign unused = ^c_addr_i[3:0];
`else
  logic         unused;
  assign unused = ^{c_addr_i[3:0], victim_dirty_i,
                    victim_line_addr_i, victim_data_i};
`endif

  assign accept = (state_q == IDLE) & c_miss_i & ~kill_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      line_q     <= '0;
      way_q      <= '0;
      rdata_q    <= '0;
      miss_cnt_q <= '0;
`ifdef DCACHE_WRITEBACK_EN
      vline_q    <= '0;
      vdata_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q <= c_addr_i[19:4];
        way_q  <= c_lru_way_i;
`ifdef DCACHE_WRITEBACK_EN
        vline_q <= victim_line_addr_i;
        vdata_q <= victim_data_i;
`endif
        if (miss_cnt_q != 32'hFFFF_FFFF)
          miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (state_q == FILL_REQ && mem_ready_i)
        rdata_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    fill_en_o    = 1'b0;
    fill_way_o   = '0;
    fill_addr_o  = '0;
    fill_data_o  = '0;
    stall_core_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall_core_o = 1'b1;
`ifdef DCACHE_WRITEBACK_EN
          state_d = victim_dirty_i ? WB_REQ : FILL_REQ;
`else
          state_d = FILL_REQ;
`endif
        end
      end
`ifdef DCACHE_WRITEBACK_EN
      WB_REQ: begin
        stall_core_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = {vline_q, 4'b0};
        mem_wdata_o  = vdata_q;
        if (mem_ready_i) state_d = FILL_REQ;
      end
`endif
      FILL_REQ: begin
        stall_core_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_addr_o   = {line_q, 4'b0};
        if (mem_ready_i) state_d = FILL;
      end
      FILL: begin
        stall_core_o = 1'b1;
        fill_en_o    = 1'b1;
        fill_way_o   = way_q;
        fill_addr_o  = {line_q, 4'b0};
        fill_data_o  = rdata_q;
        state_d      = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_dc_miss_ctrl.sv
// Scoreboard bench for dc_miss_ctrl: directed misses, memory responder,
// monitor that checks every memory completion and fill strobe.
module tb_dc_miss_ctrl;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         kill_i = 1'b0;
  logic         c_miss_i = 1'b0;
  logic [19:0]  c_addr_i = '0;
  logic [1:0]   c_lru_way_i = '0;
  logic         victim_dirty_i = 1'b0;
  logic [15:0]  victim_line_addr_i = '0;
  logic [127:0] victim_data_i = '0;
  logic         mem_req_o, mem_we_o;
  logic [19:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_rdata_i = '0;
  logic         fill_en_o;
  logic [1:0]   fill_way_o;
  logic [19:0]  fill_addr_o;
  logic [127:0] fill_data_o;
  logic         stall_core_o;
  logic [31:0]  miss_count_o;

  dc_miss_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .kill_i(kill_i), .c_miss_i(c_miss_i),
    .c_addr_i(c_addr_i), .c_lru_way_i(c_lru_way_i),
    .victim_dirty_i(victim_dirty_i),
    .victim_line_addr_i(victim_line_addr_i),
    .victim_data_i(victim_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .fill_en_o(fill_en_o), .fill_way_o(fill_way_o),
    .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .stall_core_o(stall_core_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         fill;
    logic         we;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [1:0]   way;
  } ev_t;

  ev_t sb[$];
  int vecs = 0;
  int errs = 0;
  int lat_cfg = 1;
  logic [127:0] rdata_pat = '0;
  logic [31:0]  exp_cnt = '0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cmp_ev(input ev_t g);
    ev_t e;
    if (sb.size() == 0) begin
      vecs++;
      errs++;
      $display("FAIL unexpected_event fill=%0b we=%0b addr=%h",
               g.fill, g.we, g.addr);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", {126'b0, g.fill, g.we}, {126'b0, e.fill, e.we});
      chk("ev_addr", {108'b0, g.addr}, {108'b0, e.addr});
      chk("ev_data", g.data, e.data);
      chk("ev_way", {126'b0, g.way}, {126'b0, e.way});
    end
  endtask

  // memory model: completes each request after lat_cfg cycles
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      if (mem_req_o && !rst_i) begin
        rcnt++;
        if (rcnt >= lat_cfg) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = rdata_pat;
          rcnt = 0;
        end
      end else rcnt = 0;
    end
  end

  // monitor
  initial begin
    ev_t g;
    forever begin
      @(negedge clk);
      if (!rst_i && mem_req_o && mem_ready_i) begin
        g.fill = 1'b0;
        g.we   = mem_we_o;
        g.addr = mem_addr_o;
        g.data = mem_we_o ? mem_wdata_o : '0;
        g.way  = '0;
        cmp_ev(g);
      end
      if (!rst_i && fill_en_o) begin
        g.fill = 1'b1;
        g.we   = mem_we_o;
        g.addr = fill_addr_o;
        g.data = fill_data_o;
        g.way  = fill_way_o;
        cmp_ev(g);
      end
    end
  end

  task automatic push(input logic f, input logic w, input logic [19:0] a,
                      input logic [127:0] d, input logic [1:0] wy);
    ev_t e;
    e.fill = f; e.we = w; e.addr = a; e.data = d; e.way = wy;
    sb.push_back(e);
  endtask

  task automatic do_miss(input string nm, input logic [19:0] addr,
                         input logic [1:0] way, input logic dirty,
                         input logic [15:0] vline, input logic [127:0] vdata,
                         input int lat, input logic [127:0] rdata,
                         input logic hold, input logic kill_mid,
                         input int exp_stall);
    int n = 0;
    int guard = 0;
    lat_cfg = lat;
    rdata_pat = rdata;
`ifdef DCACHE_WRITEBACK_EN
    if (dirty) push(1'b0, 1'b1, {vline, 4'b0}, vdata, 2'd0);
`endif
    push(1'b0, 1'b0, {addr[19:4], 4'b0}, '0, 2'd0);
    push(1'b1, 1'b0, {addr[19:4], 4'b0}, rdata, way);
    @(posedge clk); #1;
    c_miss_i = 1'b1;
    c_addr_i = addr;
    c_lru_way_i = way;
    victim_dirty_i = dirty;
    victim_line_addr_i = vline;
    victim_data_i = vdata;
    @(negedge clk);
    while (stall_core_o && guard < 200) begin
      n++;
      guard++;
      @(posedge clk); #1;
      if (!hold) c_miss_i = 1'b0;
      kill_i = kill_mid;
      @(negedge clk);
    end
    chk({nm, "_stall"}, 128'(n), 128'(exp_stall));
    @(posedge clk); #1;
    c_miss_i = 1'b0;
    kill_i = 1'b0;
    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    @(negedge clk);
    chk({nm, "_count"}, {96'b0, miss_count_o}, {96'b0, exp_cnt});
    chk({nm, "_stall_idle"}, {127'b0, stall_core_o}, 128'b0);
    chk({nm, "_sb_empty"}, 128'(sb.size()), 128'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req"}, {126'b0, mem_req_o, mem_we_o}, 128'b0);
    chk({nm, "_maddr"}, {108'b0, mem_addr_o}, 128'b0);
    chk({nm, "_wdata"}, mem_wdata_o, 128'b0);
    chk({nm, "_fill"}, {105'b0, fill_en_o, fill_way_o, fill_addr_o},
        128'b0);
    chk({nm, "_fdata"}, fill_data_o, 128'b0);
    chk({nm, "_stall"}, {127'b0, stall_core_o}, 128'b0);
    chk({nm, "_cnt"}, {96'b0, miss_count_o}, 128'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // clean miss, 3-cycle memory
    do_miss("clean", 20'h1234C, 2'd2, 1'b0, 16'h0, 128'h0, 3,
            128'hDEAD_BEEF_0123_4567_89AB_CDEF_FACE_CAFE,
            1'b0, 1'b0, 5);

    // dirty victim
`ifdef DCACHE_WRITEBACK_EN
    do_miss("dirty", 20'h55670, 2'd1, 1'b1, 16'h0ABC,
            128'h1111_2222_3333_4444_5555_6666_7777_8888, 2,
            128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0,
            1'b0, 1'b0, 6);
`else
    do_miss("dirty", 20'h55670, 2'd1, 1'b1, 16'h0ABC,
            128'h1111_2222_3333_4444_5555_6666_7777_8888, 2,
            128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0,
            1'b0, 1'b0, 4);
`endif

    // minimum latency, kill after acceptance is ignored
    do_miss("minlat", 20'hFFFFF, 2'd3, 1'b0, 16'h0, 128'h0, 1,
            128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F,
            1'b0, 1'b1, 3);

    // miss killed in the same cycle
    @(posedge clk); #1;
    c_miss_i = 1'b1;
    kill_i = 1'b1;
    c_addr_i = 20'h22220;
    @(negedge clk);
    chk("kill_stall", {127'b0, stall_core_o}, 128'b0);
    @(posedge clk); #1;
    c_miss_i = 1'b0;
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill_req", {127'b0, mem_req_o}, 128'b0);
    chk("kill_cnt", {96'b0, miss_count_o}, {96'b0, exp_cnt});

    // stale miss held through DONE
    do_miss("hold", 20'h00010, 2'd0, 1'b0, 16'h0, 128'h0, 1,
            128'h7777_0000_7777_0000_7777_0000_7777_0000,
            1'b1, 1'b0, 3);
    repeat (4) @(negedge clk);
    chk("hold_cnt_after", {96'b0, miss_count_o}, {96'b0, exp_cnt});

    // saturation
    @(negedge clk);
    dut.miss_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    do_miss("sat1", 20'h40000, 2'd1, 1'b0, 16'h0, 128'h0, 1,
            128'h1, 1'b0, 1'b0, 3);
    do_miss("sat2", 20'h40010, 2'd2, 1'b0, 16'h0, 128'h0, 1,
            128'h2, 1'b0, 1'b0, 3);

    // reset during FILL_REQ
    lat_cfg = 50;
    @(posedge clk); #1;
    c_miss_i = 1'b1;
    c_addr_i = 20'h33330;
    @(posedge clk); #1;
    c_miss_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_req_before", {127'b0, mem_req_o}, 128'd1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    chk_zero("rstmid");
    repeat (6) @(negedge clk);
    chk("rstmid_idle_req", {127'b0, mem_req_o}, 128'b0);
    chk("rstmid_idle_cnt", {96'b0, miss_count_o}, 128'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
